// File: rtl/txq_arbiter.sv
// rtl/txq_arbiter.sv - packet-granular round-robin merge of framed 9-bit source streams into one TX queue
//
// Ports:
//   sys_clk, sys_rst        single clock, synchronous active-high reset
//   src_dout, src_empty     per-source FWFT head word (source i at [9i+8:9i]) and empty flag
//   src_rd_en               per-source pop strobe, combinational
//   dst_din, dst_wr_en      registered TX queue write word and strobe
//   dst_full                TX queue almost-full, asserted with at least one word of margin
//   grant                   one-hot current owner, zero while idle
//   frame_cnt               frames completed including truncated ones, wraps
//   trunc_cnt               frames truncated, saturates

module txq_arbiter #(
    parameter int NPORT     = 4,
    parameter int MAX_LEN   = 2047,
    parameter int LEN_WIDTH = 12
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic [NPORT*9-1:0] src_dout,
    input  logic [NPORT-1:0]   src_empty,
    output logic [NPORT-1:0]   src_rd_en,
    output logic [8:0]         dst_din,
    input  logic               dst_full,
    output logic               dst_wr_en,
    output logic [NPORT-1:0]   grant,
    output logic [31:0]        frame_cnt,
    output logic [15:0]        trunc_cnt
);

    localparam int IDX_W = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam logic [LEN_WIDTH-1:0] LEN_LAST = LEN_WIDTH'(MAX_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        TRUNC = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [IDX_W-1:0]     owner;
    logic [IDX_W-1:0]     last_grant;
    logic [LEN_WIDTH-1:0] len;

    logic [8:0]       head [NPORT];
    logic [NPORT-1:0] is_gap;
    logic [NPORT-1:0] eligible;

    // Per-source classification of the FWFT head word.
    always_comb begin
        for (int i = 0; i < NPORT; i++) begin
            head[i]     = src_dout[9*i +: 9];
            is_gap[i]   = !src_empty[i] && !head[i][8];
            eligible[i] = !src_empty[i] &&  head[i][8];
        end
    end

    // Round-robin pick: first eligible source after last_grant, wrapping modulo NPORT.
    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W:0]   rr_sum;

    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        rr_sum     = '0;
        for (int k = 1; k <= NPORT; k++) begin
            rr_sum = {1'b0, last_grant} + (IDX_W+1)'(k);
            if (rr_sum >= (IDX_W+1)'(NPORT)) begin
                rr_sum = rr_sum - (IDX_W+1)'(NPORT);
            end
            if (!pick_valid && eligible[rr_sum[IDX_W-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = rr_sum[IDX_W-1:0];
            end
        end
    end

    // Next-state and datapath control.
    logic [8:0] own_word;
    logic       own_empty;
    logic       wr_next;
    logic [8:0] din_next;
    logic       grant_load;
    logic       grant_clear;
    logic       frame_inc;
    logic       trunc_inc;
    logic       len_inc;

    always_comb begin
        own_word    = head[owner];
        own_empty   = src_empty[owner];
        state_next  = state;
        src_rd_en   = '0;
        wr_next     = 1'b0;
        din_next    = dst_din;
        grant_load  = 1'b0;
        grant_clear = 1'b0;
        frame_inc   = 1'b0;
        trunc_inc   = 1'b0;
        len_inc     = 1'b0;

        case (state)
            IDLE: begin
                // Stray gap words are dropped from every source in parallel.
                src_rd_en = is_gap;
                if (pick_valid) begin
                    grant_load = 1'b1;
                    state_next = XFER;
                end
            end

            XFER: begin
                if (!own_empty && !dst_full) begin
                    src_rd_en[owner] = 1'b1;
                    wr_next          = 1'b1;
                    din_next         = own_word;
                    if (own_word[8]) begin
                        len_inc = 1'b1;
                        if (len == LEN_LAST) begin
                            state_next = TRUNC;
                        end
                    end else begin
                        // Delimiter is forwarded and closes the frame.
                        frame_inc   = 1'b1;
                        grant_clear = 1'b1;
                        state_next  = IDLE;
                    end
                end
            end

            TRUNC: begin
                if (!dst_full) begin
                    wr_next    = 1'b1;
                    din_next   = 9'h000;
                    frame_inc  = 1'b1;
                    trunc_inc  = 1'b1;
                    state_next = DRAIN;
                end
            end

            DRAIN: begin
                // Discard the oversize tail; the TX queue is not involved.
                if (!own_empty) begin
                    src_rd_en[owner] = 1'b1;
                    if (!own_word[8]) begin
                        grant_clear = 1'b1;
                        state_next  = IDLE;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // No source word may be consumed while the arbiter is being reset.
        if (sys_rst) begin
            src_rd_en = '0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            dst_wr_en  <= 1'b0;
            dst_din    <= 9'h000;
            grant      <= '0;
            owner      <= '0;
            last_grant <= IDX_W'(NPORT - 1);
            len        <= '0;
            frame_cnt  <= 32'd0;
            trunc_cnt  <= 16'd0;
        end else begin
            dst_wr_en <= wr_next;
            dst_din   <= din_next;
            if (grant_load) begin
                grant      <= NPORT'(1) << pick_idx;
                owner      <= pick_idx;
                last_grant <= pick_idx;
                len        <= '0;
            end else if (grant_clear) begin
                grant <= '0;
            end
            if (len_inc) begin
                len <= len + 1'b1;
            end
            if (frame_inc) begin
                frame_cnt <= frame_cnt + 32'd1;
            end
            if (trunc_inc && (trunc_cnt != 16'hFFFF)) begin
                trunc_cnt <= trunc_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_txq_arbiter.sv
// tb/tb_txq_arbiter.sv - directed vector bench for txq_arbiter
module tb_txq_arbiter;

    localparam int NP = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NP*9-1:0] s_dout  [2];
    logic [NP-1:0]   s_empty [2];
    logic [NP-1:0]   s_rd    [2];
    logic [NP-1:0]   gnt     [2];
    logic            full    [2];
    logic [8:0]      ddin    [2];
    logic            dwr     [2];
    logic [31:0]     fcnt    [2];
    logic [15:0]     tcnt    [2];

    txq_arbiter #(.NPORT(NP)) dut0 (
        .sys_clk(clk), .sys_rst(rst),
        .src_dout(s_dout[0]), .src_empty(s_empty[0]), .src_rd_en(s_rd[0]),
        .dst_din(ddin[0]), .dst_full(full[0]), .dst_wr_en(dwr[0]),
        .grant(gnt[0]), .frame_cnt(fcnt[0]), .trunc_cnt(tcnt[0])
    );

    txq_arbiter #(.NPORT(NP), .MAX_LEN(16)) dut1 (
        .sys_clk(clk), .sys_rst(rst),
        .src_dout(s_dout[1]), .src_empty(s_empty[1]), .src_rd_en(s_rd[1]),
        .dst_din(ddin[1]), .dst_full(full[1]), .dst_wr_en(dwr[1]),
        .grant(gnt[1]), .frame_cnt(fcnt[1]), .trunc_cnt(tcnt[1])
    );

    typedef struct {
        int            src;
        int            ngap;
        int            nbytes;
        int            base;
        bit            bp;
        int            frames;
        logic [NP-1:0] exp_gnt;
    } vec_t;

    logic [8:0]    srcq [2][NP][$];
    logic [8:0]    outq [2][$];
    int            outt [2][$];
    logic [8:0]    expq [2][$];
    logic [NP-1:0] glog [2][$];
    int            out_ptr [2];
    int            exp_ptr [2];
    logic [NP-1:0] prev_gnt [2];
    logic          prev_full [2];
    int            viol_full [2];
    int            viol_owner [2];
    int            viol_empty [2];
    int            cyc;
    int            n_vec;
    int            n_bad;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic refresh();
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < NP; p++) begin
                s_empty[d][p] = (srcq[d][p].size() == 0);
                s_dout[d][9*p +: 9] = (srcq[d][p].size() == 0) ? 9'h000 : srcq[d][p][0];
            end
        end
    endtask

    task automatic tick();
        logic [NP-1:0] rdp [2];
        logic [8:0]    w;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            rdp[d] = s_rd[d];
            if (dwr[d] === 1'b1) begin
                outq[d].push_back(ddin[d]);
                outt[d].push_back(cyc);
                if (prev_full[d]) viol_full[d]++;
            end
            if (gnt[d] != '0 && (s_rd[d] & ~gnt[d]) != '0) viol_owner[d]++;
            if ((s_rd[d] & s_empty[d]) != '0) viol_empty[d]++;
            if (gnt[d] != '0 && prev_gnt[d] == '0) glog[d].push_back(gnt[d]);
            prev_gnt[d]  = gnt[d];
            prev_full[d] = full[d];
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < NP; p++) begin
                if (rdp[d][p] && srcq[d][p].size() != 0) w = srcq[d][p].pop_front();
            end
        end
        refresh();
    endtask

    task automatic load(input int d, input int p, input int ngap, input int nbytes, input int base);
        for (int i = 0; i < ngap; i++) srcq[d][p].push_back(9'h000);
        for (int i = 0; i < nbytes; i++) srcq[d][p].push_back({1'b1, 8'(base + i)});
        srcq[d][p].push_back(9'h000);
        refresh();
    endtask

    task automatic expect_frame(input int d, input int nbytes, input int base);
        for (int i = 0; i < nbytes; i++) expq[d].push_back({1'b1, 8'(base + i)});
        expq[d].push_back(9'h000);
    endtask

    task automatic run_until(input int d, input int target, input bit bp, input int budget, input string name);
        int k;
        k = 0;
        while (outq[d].size() < target && k < budget) begin
            full[d] = bp ? (((k / 3) % 2) == 1) : 1'b0;
            tick();
            k++;
        end
        full[d] = 1'b0;
        check({name, " done in budget"}, 64'(outq[d].size() >= target), 64'd1);
    endtask

    task automatic check_stream(input int d, input string name);
        int n_act;
        int n_exp;
        int bad;
        int first;
        n_act = outq[d].size() - out_ptr[d];
        n_exp = expq[d].size() - exp_ptr[d];
        bad   = 0;
        first = -1;
        check({name, " word count"}, 64'(n_act), 64'(n_exp));
        for (int i = 0; i < n_exp && i < n_act; i++) begin
            if (outq[d][out_ptr[d] + i] !== expq[d][exp_ptr[d] + i]) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        check($sformatf("%s words (first bad idx %0d)", name, first), 64'(bad), 64'd0);
        out_ptr[d] = outq[d].size();
        exp_ptr[d] = expq[d].size();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [5];
        int   gptr;
        int   first_t;

        n_vec = 0; n_bad = 0; cyc = 0;
        for (int d = 0; d < 2; d++) begin
            out_ptr[d] = 0; exp_ptr[d] = 0; prev_gnt[d] = '0; prev_full[d] = 1'b0;
            viol_full[d] = 0; viol_owner[d] = 0; viol_empty[d] = 0; full[d] = 1'b0;
        end

        vecs[0] = '{0, 0,  64, 'h00, 1'b0,  9, 4'b0001};
        vecs[1] = '{2, 0, 100, 'h10, 1'b1, 10, 4'b0100};
        vecs[2] = '{3, 3,   5, 'hA0, 1'b0, 11, 4'b1000};
        vecs[3] = '{1, 0,   1, 'h55, 1'b0, 12, 4'b0010};
        vecs[4] = '{2, 0,  16, 'hF8, 1'b0, 13, 4'b0100};

        rst = 1'b1;
        for (int p = 0; p < NP; p++) begin
            for (int f = 0; f < 2; f++) load(0, p, 0, 10, p*32 + f*16);
        end
        for (int f = 0; f < 2; f++) begin
            for (int p = 0; p < NP; p++) expect_frame(0, 10, p*32 + f*16);
        end
        repeat (3) tick();

        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset dst_wr_en[%0d]", d), 64'(dwr[d]), 64'd0);
            check($sformatf("reset dst_din[%0d]", d), 64'(ddin[d]), 64'd0);
            check($sformatf("reset grant[%0d]", d), 64'(gnt[d]), 64'd0);
            check($sformatf("reset frame_cnt[%0d]", d), 64'(fcnt[d]), 64'd0);
            check($sformatf("reset trunc_cnt[%0d]", d), 64'(tcnt[d]), 64'd0);
        end

        // Round robin across all four sources, two frames each.
        rst = 1'b0;
        run_until(0, 88, 1'b0, 500, "rr");
        repeat (4) tick();
        check_stream(0, "rr");
        check("rr grant count", 64'(glog[0].size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("rr grant %0d", i), 64'(glog[0][i]), 64'(4'b0001 << (i % 4)));
        end
        check("rr frame_cnt", 64'(fcnt[0]), 64'd8);
        check("rr trunc_cnt", 64'(tcnt[0]), 64'd0);

        // Table-driven single-frame vectors.
        for (int v = 0; v < 5; v++) begin
            gptr = glog[0].size();
            first_t = outt[0].size();
            load(0, vecs[v].src, vecs[v].ngap, vecs[v].nbytes, vecs[v].base);
            expect_frame(0, vecs[v].nbytes, vecs[v].base);
            run_until(0, out_ptr[0] + vecs[v].nbytes + 1, vecs[v].bp, 2000, $sformatf("vec%0d", v));
            repeat (4) tick();
            if (!vecs[v].bp) begin
                check($sformatf("vec%0d contiguous", v),
                      64'(outt[0][outt[0].size() - 1] - outt[0][first_t]), 64'(vecs[v].nbytes));
            end
            check_stream(0, $sformatf("vec%0d", v));
            check($sformatf("vec%0d grant count", v), 64'(glog[0].size() - gptr), 64'd1);
            check($sformatf("vec%0d grant", v), 64'(glog[0][gptr]), 64'(vecs[v].exp_gnt));
            check($sformatf("vec%0d idle grant", v), 64'(gnt[0]), 64'd0);
            check($sformatf("vec%0d frame_cnt", v), 64'(fcnt[0]), 64'(vecs[v].frames));
            check($sformatf("vec%0d trunc_cnt", v), 64'(tcnt[0]), 64'd0);
            check($sformatf("vec%0d source drained", v), 64'(srcq[0][vecs[v].src].size()), 64'd0);
        end

        // Truncation at MAX_LEN=16, then an intact frame from the same source.
        load(1, 1, 0, 40, 'h40);
        load(1, 1, 0, 7, 'h90);
        expect_frame(1, 16, 'h40);
        expect_frame(1, 7, 'h90);
        run_until(1, 17, 1'b0, 500, "trunc head");
        check("trunc trunc_cnt", 64'(tcnt[1]), 64'd1);
        check("trunc frame_cnt", 64'(fcnt[1]), 64'd1);
        check("trunc grant held in drain", 64'(gnt[1]), 64'(4'b0010));
        run_until(1, 25, 1'b0, 500, "trunc next");
        repeat (4) tick();
        check_stream(1, "trunc");
        check("trunc frame_cnt after", 64'(fcnt[1]), 64'd2);
        check("trunc trunc_cnt after", 64'(tcnt[1]), 64'd1);
        check("trunc source drained", 64'(srcq[1][1].size()), 64'd0);

        // One below and exactly at the length limit.
        load(1, 2, 0, 15, 'h20);
        expect_frame(1, 15, 'h20);
        run_until(1, out_ptr[1] + 16, 1'b0, 500, "len15");
        repeat (4) tick();
        check_stream(1, "len15");
        check("len15 trunc_cnt", 64'(tcnt[1]), 64'd1);
        load(1, 2, 0, 16, 'h30);
        expect_frame(1, 16, 'h30);
        run_until(1, out_ptr[1] + 17, 1'b0, 500, "len16");
        repeat (4) tick();
        check_stream(1, "len16");
        check("len16 trunc_cnt", 64'(tcnt[1]), 64'd2);
        check("len16 frame_cnt", 64'(fcnt[1]), 64'd4);
        check("len16 delimiter drained", 64'(srcq[1][2].size()), 64'd0);

        // Reset in the middle of a 50-byte frame from source 1.
        load(0, 1, 0, 50, 'h00);
        run_until(0, out_ptr[0] + 20, 1'b0, 500, "midrst");
        load(0, 0, 0, 3, 'hE0);
        rst = 1'b1;
        tick();
        check("midrst dst_wr_en", 64'(dwr[0]), 64'd0);
        check("midrst grant", 64'(gnt[0]), 64'd0);
        check("midrst frame_cnt", 64'(fcnt[0]), 64'd0);
        check("midrst trunc_cnt", 64'(tcnt[0]), 64'd0);
        check("midrst trunc_cnt dut1", 64'(tcnt[1]), 64'd0);
        rst = 1'b0;
        out_ptr[0] = outq[0].size();
        gptr = glog[0].size();
        expect_frame(0, 3, 'hE0);
        for (int i = 0; i < srcq[0][1].size(); i++) expq[0].push_back(srcq[0][1][i]);
        run_until(0, out_ptr[0] + (expq[0].size() - exp_ptr[0]), 1'b0, 500, "postrst");
        repeat (4) tick();
        check_stream(0, "postrst");
        check("postrst first grant", 64'(glog[0][gptr]), 64'(4'b0001));
        check("postrst second grant", 64'(glog[0][gptr + 1]), 64'(4'b0010));
        check("postrst frame_cnt", 64'(fcnt[0]), 64'd2);

        for (int d = 0; d < 2; d++) begin
            check($sformatf("write while full [%0d]", d), 64'(viol_full[d]), 64'd0);
            check($sformatf("pop from non-owner [%0d]", d), 64'(viol_owner[d]), 64'd0);
            check($sformatf("pop from empty [%0d]", d), 64'(viol_empty[d]), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
